// File: rtl/rezultat_bcd.sv
// rezultat_bcd: sequential binary-to-BCD converter for the calculator result path.
// A signed two's-complement result is converted to sign + packed BCD magnitude.
// The conversion uses shift-add-3 at one bit per clock, so only one result is in flight.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   d_in       signed result from the operator block
//   err_in     operator error flag, sampled with valid_in
//   valid_in   one-cycle strobe for d_in/err_in
//   busy       conversion in progress; valid_in is ignored while high
//   valid_out  one-cycle strobe; neg/err_out/bcd updated in this cycle
//   neg        result was negative
//   err_out    error result (bcd forced to zero)
//   bcd        packed BCD, digit 0 in bits [3:0]
module rezultat_bcd #(
    parameter int unsigned WIDTH  = 28,
    parameter int unsigned DIGITS = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      d_in,
    input  logic                  err_in,
    input  logic                  valid_in,
    output logic                  busy,
    output logic                  valid_out,
    output logic                  neg,
    output logic                  err_out,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int unsigned BcdW = 4 * DIGITS;
    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StConv, StErr} state_e;

    state_e            state_q, state_d;
    logic [BcdW-1:0]   scratch_q, scratch_d;
    logic [WIDTH-1:0]  mag_q, mag_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              neg_cap_q, neg_cap_d;
    logic              valid_out_q, valid_out_d;
    logic              neg_q, neg_d;
    logic              err_q, err_d;
    logic [BcdW-1:0]   bcd_q, bcd_d;

    logic [BcdW-1:0]   adj;
    logic [BcdW-1:0]   shifted;
    logic [WIDTH-1:0]  abs_in;

    // Add-3 correction: any digit >= 5 would overflow past 9 after the doubling shift.
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
    end

    assign shifted = {adj[BcdW-2:0], mag_q[WIDTH-1]};

    // Most negative input maps to 2^(WIDTH-1), which still fits as an unsigned magnitude.
    assign abs_in = d_in[WIDTH-1] ? (~d_in) + WIDTH'(1) : d_in;

    always_comb begin
        state_d     = state_q;
        scratch_d   = scratch_q;
        mag_d       = mag_q;
        cnt_d       = cnt_q;
        neg_cap_d   = neg_cap_q;
        valid_out_d = 1'b0;
        neg_d       = neg_q;
        err_d       = err_q;
        bcd_d       = bcd_q;

        unique case (state_q)
            StIdle: begin
                if (valid_in) begin
                    if (err_in) begin
                        state_d = StErr;
                    end else begin
                        neg_cap_d = d_in[WIDTH-1];
                        mag_d     = abs_in;
                        scratch_d = '0;
                        cnt_d     = '0;
                        state_d   = StConv;
                    end
                end
            end
            StConv: begin
                scratch_d = shifted;
                mag_d     = {mag_q[WIDTH-2:0], 1'b0};
                cnt_d     = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    bcd_d       = shifted;
                    neg_d       = neg_cap_q;
                    err_d       = 1'b0;
                    valid_out_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            StErr: begin
                bcd_d       = '0;
                neg_d       = 1'b0;
                err_d       = 1'b1;
                valid_out_d = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            scratch_q   <= '0;
            mag_q       <= '0;
            cnt_q       <= '0;
            neg_cap_q   <= 1'b0;
            valid_out_q <= 1'b0;
            neg_q       <= 1'b0;
            err_q       <= 1'b0;
            bcd_q       <= '0;
        end else begin
            state_q     <= state_d;
            scratch_q   <= scratch_d;
            mag_q       <= mag_d;
            cnt_q       <= cnt_d;
            neg_cap_q   <= neg_cap_d;
            valid_out_q <= valid_out_d;
            neg_q       <= neg_d;
            err_q       <= err_d;
            bcd_q       <= bcd_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign valid_out = valid_out_q;
    assign neg       = neg_q;
    assign err_out   = err_q;
    assign bcd       = bcd_q;

endmodule

// File: tb/tb_rezultat_bcd.sv
// Self-checking bench for rezultat_bcd: expected results are queued when a result is
// accepted and compared (value and arrival cycle) whenever valid_out is seen.
module tb_rezultat_bcd;

    localparam int unsigned WIDTH  = 28;
    localparam int unsigned DIGITS = 9;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [WIDTH-1:0]    d_in = '0;
    logic                err_in = 1'b0;
    logic                valid_in = 1'b0;
    logic                busy;
    logic                valid_out;
    logic                neg;
    logic                err_out;
    logic [4*DIGITS-1:0] bcd;

    typedef struct {
        logic [4*DIGITS-1:0] bcd;
        logic                neg;
        logic                err;
        int                  due;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   n_vout = 0;

    rezultat_bcd #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .d_in      (d_in),
        .err_in    (err_in),
        .valid_in  (valid_in),
        .busy      (busy),
        .valid_out (valid_out),
        .neg       (neg),
        .err_out   (err_out),
        .bcd       (bcd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Decimal reference built by repeated division, independent of shift-add-3.
    function automatic logic [4*DIGITS-1:0] to_bcd(input longint unsigned v);
        logic [4*DIGITS-1:0] r;
        longint unsigned     t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            exp_t e;
            n_vout = n_vout + 1;
            total = total + 1;
            if (busy !== 1'b0) begin
                bad = bad + 1;
                $display("FAIL busy_with_valid_out: busy=%b required 0", busy);
            end
            total = total + 1;
            if (exp_q.size() == 0) begin
                bad = bad + 1;
                $display("FAIL unexpected_valid_out: cycle=%0d bcd=%h required no strobe", cyc, bcd);
            end else begin
                e = exp_q.pop_front();
                total = total + 4;
                if (bcd !== e.bcd) begin
                    bad = bad + 1;
                    $display("FAIL bcd: got=%h required=%h", bcd, e.bcd);
                end
                if (neg !== e.neg) begin
                    bad = bad + 1;
                    $display("FAIL neg: got=%b required=%b", neg, e.neg);
                end
                if (err_out !== e.err) begin
                    bad = bad + 1;
                    $display("FAIL err_out: got=%b required=%b", err_out, e.err);
                end
                if (cyc != e.due) begin
                    bad = bad + 1;
                    $display("FAIL latency: valid_out at cycle=%0d required=%0d", cyc, e.due);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All tasks start and end in the phase just after a rising edge (#1).
    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int d, input logic e, input logic accepted);
        exp_t x;
        longint unsigned m;
        valid_in = 1'b1;
        d_in     = d[WIDTH-1:0];
        err_in   = e;
        if (accepted) begin
            m     = (d < 0) ? longint'(-longint'(d)) : longint'(d);
            x.bcd = e ? '0 : to_bcd(m);
            x.neg = e ? 1'b0 : (d < 0);
            x.err = e;
            x.due = cyc + 1 + (e ? 1 : WIDTH);
            exp_q.push_back(x);
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        err_in   = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        total = total + 1;
        if (exp_q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL %s_timeout: pending=%0d required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_cycles(3);
        rst = 1'b0;
        total = total + 5;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got=%b required 0", busy); end
        if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid: got=%b required 0", valid_out); end
        if (neg !== 1'b0) begin bad++; $display("FAIL reset_neg: got=%b required 0", neg); end
        if (err_out !== 1'b0) begin bad++; $display("FAIL reset_err: got=%b required 0", err_out); end
        if (bcd !== '0) begin bad++; $display("FAIL reset_bcd: got=%h required 0", bcd); end
        wait_cycles(50);
        total = total + 1;
        if (n_vout != 0) begin
            bad++;
            $display("FAIL reset_idle: valid_out count=%0d required 0", n_vout);
        end
    endtask

    task automatic test_positive();
        send(3946, 1'b0, 1'b1);
        total = total + 1;
        if (busy !== 1'b1) begin bad++; $display("FAIL busy_after_accept: got=%b required 1", busy); end
        drain("positive");
        // Outputs must hold after the strobe.
        wait_cycles(5);
        total = total + 1;
        if (bcd !== 36'h000003946) begin
            bad++;
            $display("FAIL hold_bcd: got=%h required=000003946", bcd);
        end
    endtask

    task automatic test_negative_extremes();
        send(-2556, 1'b0, 1'b1);
        drain("neg_2556");
        send(-134217728, 1'b0, 1'b1);
        drain("most_negative");
        send(134217727, 1'b0, 1'b1);
        drain("most_positive");
        send(0, 1'b0, 1'b1);
        drain("zero");
    endtask

    task automatic test_error();
        send(1234, 1'b1, 1'b1);
        total = total + 1;
        if (busy !== 1'b1) begin bad++; $display("FAIL busy_err: got=%b required 1", busy); end
        drain("error");
        send(13, 1'b0, 1'b1);
        drain("after_error");
    endtask

    task automatic test_back_to_back();
        int n;
        send(169, 1'b0, 1'b1);
        wait_cycles(4);
        send(168, 1'b0, 1'b0);
        n = 0;
        while (valid_out !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        total = total + 1;
        if (valid_out !== 1'b1) begin
            bad++;
            $display("FAIL b2b_wait: valid_out=%b required 1", valid_out);
        end
        send(168, 1'b0, 1'b1);
        drain("back_to_back");
    endtask

    task automatic test_reset_mid();
        send(99999900, 1'b0, 1'b0);
        wait_cycles(9);
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        total = total + 3;
        if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got=%b required 0", busy); end
        if (bcd !== '0) begin bad++; $display("FAIL abort_bcd: got=%h required 0", bcd); end
        if (neg !== 1'b0) begin bad++; $display("FAIL abort_neg: got=%b required 0", neg); end
        wait_cycles(40);
        send(12, 1'b0, 1'b1);
        drain("after_abort");
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_positive();
        test_negative_extremes();
        test_error();
        test_back_to_back();
        test_reset_mid();
        wait_cycles(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
